// File: rtl/key_pulse_gen.sv
// Push-button front end: per-key 2-flop synchroniser, debounce and press/auto-repeat
// pulse generator. Keys are active-low in, pulses and levels active-high out.
module key_pulse_gen #(
  parameter int NKEY    = 2,
  parameter int DEB_CYC = 500000,
  parameter int REP_DLY = 25000000,
  parameter int REP_PER = 5000000,
  parameter int REP_EN  = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NKEY-1:0] nKEY,
  output logic [NKEY-1:0] PULSE,
  output logic [NKEY-1:0] LEVEL
);

  localparam int DW      = $clog2(DEB_CYC + 1);
  localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
  localparam int RW      = $clog2(REP_MAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [RW-1:0] DLY_LOAD = RW'(REP_DLY - 1);
  localparam logic [RW-1:0] PER_LOAD = RW'(REP_PER - 1);

  typedef enum logic [1:0] {
    IDLE,
    DLY,
    RPT,
    HELD
  } state_t;

  generate
    for (genvar gi = 0; gi < NKEY; gi++) begin : g_key
      logic          s1_reg;
      logic          s2_reg;
      logic [DW-1:0] deb_cnt_reg;
      logic          level_reg;
      logic          mismatch;
      logic          toggle;
      logic          rise;
      logic          fall;
      state_t        state_reg;
      state_t        state_next;
      logic [RW-1:0] rep_cnt_reg;
      logic [RW-1:0] rep_cnt_next;
      logic          pulse_reg;
      logic          pulse_next;

      // s2 is active-low, so the pressed state ~s2 disagrees with level when s2 == level.
      assign mismatch = (s2_reg == level_reg);
      assign toggle   = mismatch && (deb_cnt_reg == DEB_LAST);
      assign rise     = toggle && !level_reg;
      assign fall     = toggle && level_reg;

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          s1_reg      <= 1'b1;
          s2_reg      <= 1'b1;
          deb_cnt_reg <= '0;
          level_reg   <= 1'b0;
        end else begin
          s1_reg <= nKEY[gi];
          s2_reg <= s1_reg;
          if (!mismatch) begin
            deb_cnt_reg <= '0;
          end else if (toggle) begin
            deb_cnt_reg <= '0;
            level_reg   <= ~level_reg;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          state_reg   <= IDLE;
          rep_cnt_reg <= '0;
          pulse_reg   <= 1'b0;
        end else begin
          state_reg   <= state_next;
          rep_cnt_reg <= rep_cnt_next;
          pulse_reg   <= pulse_next;
        end
      end

      // The FSM reacts to the debounce toggle in the same edge LEVEL changes, so the
      // first pulse lines up with LEVEL rising and release suppresses a coincident repeat.
      always_comb begin
        state_next   = state_reg;
        rep_cnt_next = rep_cnt_reg;
        pulse_next   = 1'b0;
        if (fall) begin
          state_next   = IDLE;
          rep_cnt_next = '0;
        end else begin
          case (state_reg)
            IDLE: begin
              if (rise) begin
                pulse_next   = 1'b1;
                rep_cnt_next = DLY_LOAD;
                state_next   = (REP_EN != 0) ? DLY : HELD;
              end
            end
            DLY, RPT: begin
              if (rep_cnt_reg == '0) begin
                pulse_next   = 1'b1;
                rep_cnt_next = PER_LOAD;
                state_next   = RPT;
              end else begin
                rep_cnt_next = rep_cnt_reg - 1'b1;
              end
            end
            HELD: begin
              rep_cnt_next = '0;
            end
            default: begin
              state_next   = IDLE;
              rep_cnt_next = '0;
            end
          endcase
        end
      end

      assign PULSE[gi] = pulse_reg;
      assign LEVEL[gi] = level_reg;
    end
  endgenerate

endmodule
